p_cacheline_burst_adapter: RTL



---
 rtl/p_cache_pkg.sv | 12 +
 rtl/p_burst_beat_counter.sv | 22 ++
 rtl/p_cacheline_burst_adapter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/p_cache_pkg.sv
// Shared types and sizes for the cache-line <-> memory burst path.
package p_cache_pkg;
  localparam int LINE_W      = 256;
  localparam int BEAT_W      = 64;
  localparam int BEATS       = LINE_W / BEAT_W;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} burst_state_t;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [BEAT_W-1:0] beat_t;
endpackage

// File: rtl/p_burst_beat_counter.sv
// Two-bit beat index shared by the read-assembly and write-serialise paths.
module p_burst_beat_counter
  import p_cache_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clear,
  output logic [1:0] cnt,
  output logic       last
);

  // Clear wins over inc; natural 3->0 wrap lines up with burst completion.
  always_ff @(posedge clk) begin
    if (!rst_n)     cnt <= 2'd0;
    else if (clear) cnt <= 2'd0;
    else if (inc)   cnt <= cnt + 2'd1;
  end

  assign last = (cnt == 2'(BEATS - 1));

endmodule

// File: rtl/p_cacheline_burst_adapter.sv
// One 256-bit cache line <-> four 64-bit memory beats, single outstanding
// transaction. Optional perf counters under `P_BURST_PERF_CNT_EN`.
module p_cacheline_burst_adapter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
`ifdef P_BURST_PERF_CNT_EN
  ,
  output logic [31:0]       rd_bursts_o,
  output logic [31:0]       wr_bursts_o,
  output logic [31:0]       stall_cycles_o
`endif
);
  import p_cache_pkg::*;

  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~{{(ADDR_W-OFFSET_BITS){1'b0}}, {OFFSET_BITS{1'b1}}};

  burst_state_t state;
  line_t        wbuf;
  logic [1:0]   cnt;
  logic         last;
  logic         in_burst;
  logic         beat_ack;

  assign in_burst = (state == RD_BURST) || (state == WR_BURST);
  // Beats outside a burst (IDLE/DONE stragglers) are never counted.
  assign beat_ack = in_burst && resp_i;

  p_burst_beat_counter u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (beat_ack),
    .clear (state == DONE),
    .cnt   (cnt),
    .last  (last)
  );

  // Transaction FSM, request latch and read-line assembly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      address_o <= '0;
      wbuf      <= '0;
      line_o    <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i) begin
            address_o <= address_i & LINE_MASK;
            wbuf      <= line_i;
            write_o   <= 1'b1;
            state     <= WR_BURST;
          end else if (read_i) begin
            address_o <= address_i & LINE_MASK;
            read_o    <= 1'b1;
            state     <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (resp_i) begin
            line_o[BEAT_W*cnt +: BEAT_W] <= burst_i;
            if (last) begin
              read_o <= 1'b0;
              state  <= DONE;
            end
          end
        end
        WR_BURST: begin
          if (resp_i && last) begin
            write_o <= 1'b0;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Current write beat follows the counter; zero outside a write burst.
  always_comb begin
    burst_o = '0;
    if (state == WR_BURST) burst_o = wbuf[BEAT_W*cnt +: BEAT_W];
  end

  assign resp_o = (state == DONE);

`ifdef P_BURST_PERF_CNT_EN
  // Saturating completion and stall counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_bursts_o    <= '0;
      wr_bursts_o    <= '0;
      stall_cycles_o <= '0;
    end else begin
      if (state == RD_BURST && resp_i && last && rd_bursts_o != '1)
        rd_bursts_o <= rd_bursts_o + 32'd1;
      if (state == WR_BURST && resp_i && last && wr_bursts_o != '1)
        wr_bursts_o <= wr_bursts_o + 32'd1;
      if (in_burst && !resp_i && stall_cycles_o != '1)
        stall_cycles_o <= stall_cycles_o + 32'd1;
    end
  end
`endif

endmodule
